// File: rtl/oled_task_controller.sv
// oled_task_controller: debounced button control of display mode/level, delivered over valid/ready
// Ports:
//   CLK                 system clock
//   RSTn                asynchronous active-low reset
//   CTRLbtn             raw mode button (asynchronous)
//   UPbtn / DOWNbtn     raw level buttons (asynchronous)
//   cfg_ready           datapath accepts the offered configuration this cycle
//   cfg_valid           cfg_mode/cfg_level carry a new configuration
//   cfg_mode[1:0]       offered mode
//   cfg_level[3:0]      offered level
module oled_task_controller #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int LEVEL_MAX       = 9,
    parameter int NUM_MODES       = 4
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       CTRLbtn,
    input  logic       UPbtn,
    input  logic       DOWNbtn,
    input  logic       cfg_ready,
    output logic       cfg_valid,
    output logic [1:0] cfg_mode,
    output logic [3:0] cfg_level
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(RMAX + 1);
    localparam logic [CW-1:0] DB_END   = CW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] DLY_END  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_END = TW'(REPEAT_RATE - 1);
    localparam logic [3:0]    LMAX     = 4'(LEVEL_MAX);
    localparam logic [1:0]    MLAST    = 2'(NUM_MODES - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    // bit 0 = CTRL, bit 1 = UP, bit 2 = DOWN
    logic [2:0] raw, s1_q, s2_q, db, dbp_q, rise;
    assign raw  = {DOWNbtn, UPbtn, CTRLbtn};
    assign rise = db & ~dbp_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s1_q  <= '0;
            s2_q  <= '0;
            dbp_q <= '0;
        end else begin
            s1_q  <= raw;
            s2_q  <= s1_q;
            dbp_q <= db;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [CW-1:0] cnt_q;
        logic          db_q;
        assign db[i] = db_q;
        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else if (s2_q[i] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_END) begin
                cnt_q <= '0;
                db_q  <= ~db_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    state_t        state_q;
    logic          dir_q;
    logic [TW-1:0] tmr_q;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    level_q, level_d;
    logic          held, other, start_up, start_dn, abort, tick, step, sdir;

    // dir_q: 0 = UP held, 1 = DOWN held
    always_comb begin
        held     = dir_q ? db[2] : db[1];
        other    = dir_q ? db[1] : db[2];
        start_up = rise[1] & ~db[2];
        start_dn = rise[2] & ~db[1];
        abort    = (state_q != IDLE) && (!held || other);
        tick     = (state_q == DELAY && tmr_q == DLY_END) || (state_q == REPEAT && tmr_q == RATE_END);
        step     = state_q == IDLE ? (start_up | start_dn) : (tick & ~abort);
        sdir     = state_q == IDLE ? start_dn : dir_q;
        mode_d   = rise[0] ? (mode_q >= MLAST ? 2'd0 : mode_q + 2'd1) : mode_q;
        level_d  = rise[0] ? 4'd0 :
                   !step   ? level_q :
                   sdir    ? (level_q == 4'd0 ? 4'd0 : level_q - 4'd1) :
                             (level_q >= LMAX ? LMAX : level_q + 4'd1);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            tmr_q   <= '0;
            mode_q  <= '0;
            level_q <= '0;
        end else begin
            mode_q  <= mode_d;
            level_q <= level_d;
            if (state_q == IDLE) begin
                if (start_up | start_dn) begin
                    state_q <= DELAY;
                    dir_q   <= start_dn;
                end
                tmr_q <= '0;
            end else if (abort) begin
                state_q <= IDLE;
                tmr_q   <= '0;
            end else if (tick) begin
                state_q <= REPEAT;
                tmr_q   <= '0;
            end else begin
                tmr_q <= tmr_q + 1'b1;
            end
        end
    end

    logic       cfg_valid_q, last_vld_q;
    logic [1:0] cfg_mode_q;
    logic [3:0] cfg_level_q;
    logic [5:0] last_q;

    // last_vld_q=0 marks "nothing accepted yet" so (0,0) is still offered after reset
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cfg_valid_q <= 1'b0;
            cfg_mode_q  <= '0;
            cfg_level_q <= '0;
            last_vld_q  <= 1'b0;
            last_q      <= '0;
        end else if (cfg_valid_q) begin
            if (cfg_ready) begin
                cfg_valid_q <= 1'b0;
                last_q      <= {cfg_mode_q, cfg_level_q};
                last_vld_q  <= 1'b1;
            end
        end else if (!last_vld_q || {mode_q, level_q} != last_q) begin
            cfg_valid_q <= 1'b1;
            cfg_mode_q  <= mode_q;
            cfg_level_q <= level_q;
        end
    end

    assign cfg_valid = cfg_valid_q;
    assign cfg_mode  = cfg_mode_q;
    assign cfg_level = cfg_level_q;
endmodule

// File: tb/tb_oled_task_controller.sv
// tb_oled_task_controller: directed and randomized checks of oled_task_controller against a behavioural model
module tb_oled_task_controller;
    localparam int D = 4, RD = 20, RR = 5, LM = 9, NM = 4;

    logic       CLK = 0, RSTn = 0, CTRLbtn = 0, UPbtn = 0, DOWNbtn = 0, cfg_ready = 0;
    logic       cfg_valid;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_level;
    int         n_chk = 0, n_pass = 0;
    int         logq[$], expq[$];

    oled_task_controller #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .LEVEL_MAX(LM), .NUM_MODES(NM)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .CTRLbtn(CTRLbtn), .UPbtn(UPbtn), .DOWNbtn(DOWNbtn),
        .cfg_ready(cfg_ready), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_level(cfg_level)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: debounce as a sliding window of raw samples, auto-repeat as
    // an age count since the first step, handshake as "offer whatever differs from last accepted".
    bit [15:0] h[3];
    bit        mdb[3], mrise[3];
    bit        m_act, m_dir, mv;
    int        m_age, mmode, mlevel, ocm, ocl, last;

    always @(posedge CLK or negedge RSTn) begin : mdl
        bit step, held, other, ok;
        bit r[3];
        if (!RSTn) begin
            for (int x = 0; x < 3; x++) begin
                h[x] = 0; mdb[x] = 0; mrise[x] = 0;
            end
            m_act = 0; m_dir = 0; m_age = 0; mmode = 0; mlevel = 0;
            mv = 0; ocm = 0; ocl = 0; last = -1;
        end else begin
            if (mv && cfg_ready) begin
                mv = 0; last = ocm * 16 + ocl;
            end else if (!mv && mmode * 16 + mlevel != last) begin
                mv = 1; ocm = mmode; ocl = mlevel;
            end
            step = 0;
            if (m_act) begin
                held  = m_dir ? mdb[2] : mdb[1];
                other = m_dir ? mdb[1] : mdb[2];
                if (!held || other) m_act = 0;
                else begin
                    m_age++;
                    step = (m_age == RD) || (m_age > RD && (m_age - RD) % RR == 0);
                end
            end else if (mrise[1] && !mdb[2]) begin
                m_act = 1; m_dir = 0; m_age = 0; step = 1;
            end else if (mrise[2] && !mdb[1]) begin
                m_act = 1; m_dir = 1; m_age = 0; step = 1;
            end
            if (mrise[0]) begin
                mmode = (mmode + 1) % NM; mlevel = 0;
            end else if (step) begin
                mlevel = m_dir ? (mlevel > 0 ? mlevel - 1 : 0) : (mlevel < LM ? mlevel + 1 : LM);
            end
            r[0] = CTRLbtn; r[1] = UPbtn; r[2] = DOWNbtn;
            for (int x = 0; x < 3; x++) begin
                h[x] = {h[x][14:0], r[x]};
                ok = 1;
                for (int j = 2; j <= D + 2; j++) if (h[x][j] == mdb[x]) ok = 0;
                mrise[x] = 0;
                if (ok) begin
                    mdb[x] = !mdb[x]; mrise[x] = mdb[x];
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (RSTn) begin
            chk("valid", int'(cfg_valid), int'(mv));
            chk("mode", int'(cfg_mode), ocm);
            chk("level", int'(cfg_level), ocl);
        end
    end

    always @(posedge CLK) if (RSTn && cfg_valid && cfg_ready) logq.push_back(cfg_mode * 16 + cfg_level);

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic setb(input int b, input bit v);
        case (b)
            0: CTRLbtn = v;
            1: UPbtn = v;
            default: DOWNbtn = v;
        endcase
    endtask

    task automatic press(input int b, input int n);
        setb(b, 1); cyc(n); setb(b, 0); cyc(20);
    endtask

    task automatic chk_seq(input string nm);
        chk({nm, "_count"}, logq.size(), expq.size());
        for (int i = 0; i < logq.size() && i < expq.size(); i++) chk(nm, logq[i], expq[i]);
        logq.delete();
        expq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, cd[3];
        cfg_ready = 1;
        cyc(2);
        chk("rst_valid", int'(cfg_valid), 0);
        chk("rst_mode", int'(cfg_mode), 0);
        chk("rst_level", int'(cfg_level), 0);
        RSTn = 1;
        @(negedge CLK);
        chk("init_valid", int'(cfg_valid), 1);
        chk("init_pair", cfg_mode * 16 + cfg_level, 0);
        @(negedge CLK);
        chk("init_drop", int'(cfg_valid), 0);
        cyc(5);
        expq = {0}; chk_seq("init");

        UPbtn = 1; cyc(3); UPbtn = 0; cyc(20);
        chk_seq("glitch");

        UPbtn = 1; n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (cfg_valid) begin n = i; break; end
        end
        chk("press_latency", n, 9);
        chk("press_level", int'(cfg_level), 1);
        cyc(2); UPbtn = 0; cyc(20);
        expq = {1}; chk_seq("press");

        press(2, 10);
        expq = {0}; chk_seq("down_once");
        press(1, 80);
        chk("sat_up", int'(cfg_level), 9);
        expq = {1, 2, 3, 4, 5, 6, 7, 8, 9}; chk_seq("repeat_up");
        press(2, 80);
        chk("sat_down", int'(cfg_level), 0);
        expq = {8, 7, 6, 5, 4, 3, 2, 1, 0}; chk_seq("repeat_down");

        repeat (5) press(1, 10);
        expq = {1, 2, 3, 4, 5}; chk_seq("to_five");
        repeat (5) press(0, 10);
        chk("wrap_mode", int'(cfg_mode), 1);
        expq = {16, 32, 48, 0, 16}; chk_seq("mode_wrap");

        cfg_ready = 0;
        repeat (3) press(1, 10);
        chk("bp_valid", int'(cfg_valid), 1);
        chk("bp_level", int'(cfg_level), 1);
        cfg_ready = 1;
        @(negedge CLK); chk("bp_idle", int'(cfg_valid), 0);
        @(negedge CLK); chk("bp_next_valid", int'(cfg_valid), 1);
        chk("bp_next_level", int'(cfg_level), 3);
        @(negedge CLK); chk("bp_done", int'(cfg_valid), 0);
        cyc(5);
        expq = {17, 19}; chk_seq("coalesce");

        UPbtn = 1; DOWNbtn = 1; cyc(15); UPbtn = 0; DOWNbtn = 0; cyc(20);
        chk_seq("up_down");
        CTRLbtn = 1; UPbtn = 1; cyc(10); CTRLbtn = 0; UPbtn = 0; cyc(20);
        expq = {32}; chk_seq("ctrl_wins");

        cfg_ready = 0;
        press(1, 10);
        chk("mid_valid", int'(cfg_valid), 1);
        #2 RSTn = 0;
        #1;
        chk("mid_rst_valid", int'(cfg_valid), 0);
        chk("mid_rst_pair", cfg_mode * 16 + cfg_level, 0);
        cyc(2);
        cfg_ready = 1; RSTn = 1;
        @(negedge CLK);
        chk("mid_init_valid", int'(cfg_valid), 1);
        chk("mid_init_pair", cfg_mode * 16 + cfg_level, 0);
        cyc(10);
        logq.delete();

        for (int x = 0; x < 3; x++) cd[x] = $urandom_range(1, 40);
        repeat (3000) begin
            @(negedge CLK);
            cfg_ready = $urandom_range(0, 3) != 0;
            for (int x = 0; x < 3; x++) begin
                cd[x]--;
                if (cd[x] == 0) begin
                    case (x)
                        0: CTRLbtn = ~CTRLbtn;
                        1: UPbtn = ~UPbtn;
                        default: DOWNbtn = ~DOWNbtn;
                    endcase
                    cd[x] = $urandom_range(1, 40);
                end
            end
        end
        CTRLbtn = 0; UPbtn = 0; DOWNbtn = 0; cfg_ready = 1;
        cyc(30);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/oled_task_controller.md
# oled_task_controller

Button-driven configuration controller for the OLED task datapath. It synchronises and debounces the three board buttons (CTRLbtn, UPbtn, DOWNbtn), keeps a display mode and a level setting, and generates press/auto-repeat events from them. Each new configuration is delivered to the task datapath over a valid/ready handshake, so the datapath applies changes only at its own frame boundary.

## Interface
- DEBOUNCE_CYCLES, 200000: consecutive stable cycles required to accept a button change (2 ms at 100 MHz).
- REPEAT_DELAY, 50000000: cycles UP/DOWN must be held after the first step before auto-repeat starts.
- REPEAT_RATE, 10000000: cycles between auto-repeat steps.
- LEVEL_MAX, 9: highest level value. Range 1..15.
- NUM_MODES, 4: number of modes. Range 2..4.
- CLK  in  1  system clock, 100 MHz.
- RSTn  in  1  asynchronous, active-low reset.
- CTRLbtn  in  1  raw mode button, asynchronous to CLK.
- UPbtn  in  1  raw level-up button, asynchronous to CLK.
- DOWNbtn  in  1  raw level-down button, asynchronous to CLK.
- cfg_ready  in  1  datapath can accept a configuration this cycle.
- cfg_valid  out  1  cfg_mode and cfg_level hold a new configuration.
- cfg_mode  out  2  mode being offered.
- cfg_level  out  4  level being offered.

## Operation
- **Synchronisers:** each button passes through a 2-flop synchroniser.
- **Debounce:** each synchronised button has its own counter, width $clog2(DEBOUNCE_CYCLES+1). The counter clears whenever the input equals the debounced state. The debounced state toggles when the counter reaches DEBOUNCE_CYCLES.
- **CTRL:** a debounced rising edge advances mode, wrapping from NUM_MODES-1 to 0, and clears level to 0.
- **UP/DOWN repeat FSM** (one instance shared by UP and DOWN): states IDLE, DELAY, REPEAT.
  - IDLE -> DELAY: on a debounced rising edge of exactly one of UP or DOWN. Emit one step and clear the timer.
  - DELAY -> REPEAT: when the timer reaches REPEAT_DELAY. Emit one step and clear the timer.
  - REPEAT: emit one step each time the timer reaches REPEAT_RATE, then clear the timer.
  - Any state -> IDLE: when the held button releases, or when the other button becomes pressed.
- **Step rules:** UP gives level+1, saturating at LEVEL_MAX. DOWN gives level-1, saturating at 0. A step at saturation changes nothing and starts no transfer.
- **Simultaneous events:**
  - UP and DOWN both debounced high: no step; the FSM stays in IDLE until both are released.
  - CTRL edge in the same cycle as a step: the CTRL action wins and the step is discarded.
- **Handshake:** the internal mode_r/level_r are separate from the output registers cfg_mode/cfg_level.
  - When cfg_valid=0 and (mode_r, level_r) differs from the last accepted pair, load the outputs and set cfg_valid=1 on the next edge.
  - While cfg_valid=1 and cfg_ready=0, cfg_mode/cfg_level hold stable, even if mode_r/level_r keep changing.
  - On cfg_valid&cfg_ready, cfg_valid drops on the next edge and the accepted pair is recorded as last accepted.
  - Changes made during a pending transfer coalesce: only the latest pair is sent next, after one cycle with cfg_valid low.
- **Reset** (asynchronous, RSTn=0):
  - Outputs: cfg_valid=0, cfg_mode=0, cfg_level=0.
  - Internal: mode_r=0, level_r=0, FSM in IDLE, all counters 0.
  - Debounced states and synchroniser flops reset to 0.
  - The last-accepted pair resets to an "invalid" marker, so an initial transfer of (0,0) raises cfg_valid on the first edge after RSTn rises.
  - Reset mid-transfer drops the pending transfer.

## Timing
- Press latency:
  - Raw button rises at edge 0 and stays high.
  - Debounced state rises at edge DEBOUNCE_CYCLES+2.
  - mode_r/level_r update at +3.
  - cfg_valid rises at +4, provided the handshake is idle.
- Release has the same debounce latency; release produces no event.
- Auto-repeat steps occur REPEAT_DELAY cycles after the first step, then every REPEAT_RATE cycles.
- cfg_ready may be high continuously. Each transfer then occupies exactly one cycle of cfg_valid.
- Minimum spacing between two transfers is 2 cycles: valid, then one idle cycle.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, LEVEL_MAX=9, NUM_MODES=4.

1. **Reset and initial transfer:** release RSTn with cfg_ready=1 -> cfg_valid=1 for one cycle with mode 0 / level 0, then 0.
2. **Debounce:** 3-cycle UP glitch -> no transfer. A clean UP press -> cfg_level=1, with cfg_valid rising 8 cycles after the press.
3. **Auto-repeat and saturation:** hold UP for 80 cycles -> levels 1 and 2, then one step every 5 cycles, saturating at 9 with no further transfers. Hold DOWN -> level walks down to 0 and stops.
4. **Mode wrap:** five CTRL presses from mode 0 with level 5 -> modes 1, 2, 3, 0, 1, each with level 0.
5. **Backpressure and coalescing:** hold cfg_ready=0 and press UP three times -> first offer (level 1) stays stable throughout. Raise cfg_ready -> level 1 accepted, one idle cycle, then a single offer of level 3.
6. **Conflicts and reset mid-operation:**
   - UP and DOWN pressed together -> no transfer.
   - CTRL and UP debounced in the same cycle -> mode+1, level 0.
   - RSTn pulsed low while cfg_valid=1 -> outputs 0 immediately, then the initial transfer of (0,0).
